// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and encodings for the CPU control sequencer
package cpu_ctrl_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DECODE  = 2'd1,
        EXECUTE = 2'd2,
        HALT    = 2'd3
    } state_t;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [6:0] F7_ADD = 7'b0000000;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    // Everything decoded from one instruction, captured together on DECODE->EXECUTE
    typedef struct packed {
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic        aluSrc;
        logic [2:0]  aluCtrl;
        logic        wrEn;
        logic        isBranch;
        logic        isBne;
        logic        illegal;
    } ctrl_t;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - I-type and B-type immediate extraction with sign extension
module imm_gen (
    input  logic [31:0] instr,
    output logic [31:0] iImm,
    output logic [31:0] bImm
);

    logic unusedBits;

    assign iImm = {{20{instr[31]}}, instr[31:20]};
    assign bImm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};

    assign unusedBits = ^{instr[19:12], instr[6:0]};

endmodule

// File: rtl/cpu_ctrl_fsm.sv
// rtl/cpu_ctrl_fsm.sv - multi-cycle fetch/decode/execute sequencer for a minimal RV32I subset
module cpu_ctrl_fsm
    import cpu_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        eq,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [31:0] ImmOp,
    output logic        aluSrc,
    output logic [2:0]  aluCtrl,
    output logic        RegWrite,
    output logic        halted,
    output logic [31:0] retired
);

    state_t      state;
    state_t      nextState;
    ctrl_t       ctrlD;
    ctrl_t       ctrlQ;
    logic [31:0] pc;
    logic [31:0] iImm;
    logic [31:0] bImm;
    logic [31:0] branchTarget;
    logic [31:0] nextPc;
    logic        taken;
    logic        badTarget;
    logic        haltNow;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;

    assign opcode = imem_rdata[6:0];
    assign funct3 = imem_rdata[14:12];
    assign funct7 = imem_rdata[31:25];

    imm_gen u_imm_gen (
        .instr (imem_rdata),
        .iImm  (iImm),
        .bImm  (bImm)
    );

    always_comb begin
        ctrlD = '0;
        case (opcode)
            OP_IMM: begin
                if (funct3 == F3_ADD) begin
                    ctrlD.rs1     = imem_rdata[19:15];
                    ctrlD.rd      = imem_rdata[11:7];
                    ctrlD.imm     = iImm;
                    ctrlD.aluSrc  = 1'b1;
                    ctrlD.aluCtrl = ALU_ADD;
                    ctrlD.wrEn    = (imem_rdata[11:7] != 5'd0);
                end else begin
                    ctrlD.illegal = 1'b1;
                end
            end
            OP_REG: begin
                if (funct3 == F3_ADD && funct7 == F7_ADD) begin
                    ctrlD.rs1     = imem_rdata[19:15];
                    ctrlD.rs2     = imem_rdata[24:20];
                    ctrlD.rd      = imem_rdata[11:7];
                    ctrlD.aluCtrl = ALU_ADD;
                    ctrlD.wrEn    = (imem_rdata[11:7] != 5'd0);
                end else begin
                    ctrlD.illegal = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (funct3 == F3_BEQ || funct3 == F3_BNE) begin
                    ctrlD.rs1      = imem_rdata[19:15];
                    ctrlD.rs2      = imem_rdata[24:20];
                    ctrlD.imm      = bImm;
                    ctrlD.aluCtrl  = ALU_SUB;
                    ctrlD.isBranch = 1'b1;
                    ctrlD.isBne    = (funct3 == F3_BNE);
                end else begin
                    ctrlD.illegal = 1'b1;
                end
            end
            default: ctrlD.illegal = 1'b1;
        endcase
    end

    // Branch resolution uses eq as seen at the end of EXECUTE
    assign taken        = ctrlQ.isBranch && (ctrlQ.isBne ? !eq : eq);
    assign branchTarget = pc + ctrlQ.imm;
    assign badTarget    = taken && branchTarget[1];
    assign nextPc       = taken ? branchTarget : pc + 32'd4;
    assign haltNow      = ctrlQ.illegal || badTarget;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FETCH;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            FETCH:   nextState = en ? DECODE : FETCH;
            DECODE:  nextState = EXECUTE;
            EXECUTE: nextState = haltNow ? HALT : FETCH;
            HALT:    nextState = HALT;
            default: nextState = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc      <= RESET_PC;
            retired <= 32'd0;
            halted  <= 1'b0;
            ctrlQ   <= '0;
        end else begin
            if (state == DECODE) begin
                ctrlQ <= ctrlD;
            end
            if (state == EXECUTE) begin
                if (haltNow) begin
                    halted <= 1'b1;
                end else begin
                    pc      <= nextPc;
                    retired <= retired + 32'd1;
                end
            end
        end
    end

    // Gating with rst keeps a reset edge from ever committing a register write
    always_comb begin
        RegWrite = (state == EXECUTE) && ctrlQ.wrEn && !rst;
    end

    assign imem_addr = pc;
    assign rs1       = ctrlQ.rs1;
    assign rs2       = ctrlQ.rs2;
    assign rd        = ctrlQ.rd;
    assign ImmOp     = ctrlQ.imm;
    assign aluSrc    = ctrlQ.aluSrc;
    assign aluCtrl   = ctrlQ.aluCtrl;

endmodule

// File: doc/cpu_ctrl_fsm.md
# cpu_ctrl_fsm

Multi-cycle fetch/decode/control sequencer that drives the execute datapath (register file, ALU operand mux, ALU) of the bare-bones CPU. It owns the program counter, fetches from a synchronous instruction memory, decodes a minimal RV32I subset (ADDI, ADD, BEQ, BNE), and issues register addresses, immediate, mux select, ALU control and write-enable. It consumes the ALU `eq` flag to resolve branches.

## Interface
- `RESET_PC`, 32'h0000_0000, PC value loaded on reset
- `clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `en`  in  1  run enable, sampled only in FETCH
- `imem_addr`  out  32  instruction byte address, always equals PC
- `imem_rdata`  in  32  instruction word, valid one cycle after `imem_addr` is presented
- `eq`  in  1  ALU equality flag, combinational from current operands
- `rs1`, `rs2`, `rd`  out  5 each  register file addresses
- `ImmOp`  out  32  sign-extended immediate
- `aluSrc`  out  1  0 = register operand 2, 1 = `ImmOp`
- `aluCtrl`  out  3  3'b000 add, 3'b001 sub
- `RegWrite`  out  1  register file write enable, one-cycle pulse
- `halted`  out  1  sticky halt flag
- `retired`  out  32  count of completed instructions, wraps mod 2^32

## Operation
- States: FETCH -> DECODE -> EXECUTE -> FETCH; HALT is terminal until reset.
- FETCH: `imem_addr` = PC. Advance to DECODE only when `en`=1, else hold.
- DECODE: latch `imem_rdata`, decode into registered control outputs, advance to EXECUTE. `en` ignored.
- EXECUTE: outputs stable; `RegWrite` high; PC updated and `retired` incremented at end of cycle; next state FETCH (or HALT).
- ADDI (opcode 0010011, funct3 000): `rs1`, `rd` from instr, `ImmOp` = sext(instr[31:20]), `aluSrc`=1, `aluCtrl`=000, write.
- ADD (0110011, funct3 000, funct7 0000000): `aluSrc`=0, `aluCtrl`=000, write.
- BEQ/BNE (1100011, funct3 000/001): `aluSrc`=0, `aluCtrl`=001, no write; `ImmOp` = sext B-immediate {instr[31],instr[7],instr[30:25],instr[11:8],1'b0}. Taken: BEQ when `eq`=1, BNE when `eq`=0. Taken PC = PC + `ImmOp`, else PC + 4; addition mod 2^32.
- `rd`=0: `RegWrite` suppressed, instruction still retires.
- Illegal: any other opcode/funct3/funct7, or taken branch target with bit 1 set. Outputs as NOP (`RegWrite`=0), PC not updated, `retired` not incremented, enter HALT, `halted`=1.
- HALT: PC, `imem_addr`, `retired` frozen; `RegWrite`=0; only `rst` exits.
- `RegWrite` = registered enable AND NOT `rst`, so no write occurs on a reset edge.

## Timing
- Reset values: PC=`RESET_PC`, state FETCH, `rs1`/`rs2`/`rd`=0, `ImmOp`=0, `aluSrc`=0, `aluCtrl`=000, `RegWrite`=0, `halted`=0, `retired`=0.
- 3 cycles per instruction with `en` held high; first EXECUTE is cycle 3 after reset release.
- Control outputs change only on DECODE->EXECUTE edge and on reset; they hold through the following FETCH/DECODE.
- `eq` is sampled at the end of EXECUTE only.
- `rst` in any state, including mid-EXECUTE: abort instruction, no write, no PC/`retired` update, reset values next cycle.
- `en` dropped after FETCH: current instruction completes; the sequencer then waits in FETCH.

## Structure
- `cpu_ctrl_pkg`: state enum, opcode/funct3/funct7 constants, `aluCtrl` encodings.
- Sub-module `imm_gen`: combinational I-/B-immediate extraction and sign extension.

## Test plan
- Reset with `en`=1 -> `imem_addr`=0, `RegWrite`=0, `halted`=0, `retired`=0; first EXECUTE at cycle 3.
- `imem_rdata`=0x00500093 (addi x1,x0,5) -> EXECUTE: `rd`=1, `rs1`=0, `ImmOp`=5, `aluSrc`=1, `aluCtrl`=000, `RegWrite`=1; PC 0->4, `retired`=1.
- At PC 8, `imem_rdata`=0xFE209EE3 (bne x1,x2,-4): `eq`=0 -> PC=4; `eq`=1 -> PC=12; `ImmOp`=0xFFFF_FFFC, `aluCtrl`=001, `RegWrite`=0 in both cases.
- `imem_rdata`=0x00700013 (addi x0,x0,7) -> `RegWrite` stays 0, PC+4, `retired` increments.
- `imem_rdata`=0xFFFFFFFF -> `halted`=1 after EXECUTE; PC and `retired` frozen for 20 cycles; `rst` pulse clears `halted`, PC=`RESET_PC`.
- `en`=0 in FETCH holds PC for 5 cycles; `rst` asserted during EXECUTE of addi -> `RegWrite`=0 that cycle, register write absent, PC=`RESET_PC` next cycle.
